// File: rtl/transpose_row_loader_if.sv
// Row-stream handshake and matrix presentation bundle between a row feeder and the
// transpose row loader; the loader side uses the slave modport.
interface transpose_row_loader_if #(
  parameter int CHUNK_WIDTH = 64,
  parameter int NUM_PE      = 8
);
  logic                                         flush;
  logic                                         in_valid;
  logic                                         in_ready;
  logic [0:NUM_PE-1][CHUNK_WIDTH-1:0]           in_row;
  logic                                         xpose_ctrl;
  logic [0:NUM_PE-1][0:NUM_PE-1][CHUNK_WIDTH-1:0] mat_elements;
  logic                                         busy;
  logic                                         done;

  modport master (
    output flush, in_valid, in_row,
    input  in_ready, xpose_ctrl, mat_elements, busy, done
  );

  modport slave (
    input  flush, in_valid, in_row,
    output in_ready, xpose_ctrl, mat_elements, busy, done
  );
endinterface

// File: rtl/transpose_row_loader.sv
// Collects NUM_PE rows into a chunk matrix, then holds xpose_ctrl for HOLD_CYCLES+1 cycles
// and pulses done; in_ready is low from the last accepted row until the loader re-arms.
module transpose_row_loader #(
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_PE      = 8,
  parameter int NUM_MG      = 8,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  transpose_row_loader_if.slave bus
);
  localparam int CHUNK_WIDTH = NUM_MG / NUM_PE * DATA_WIDTH;
  localparam int RW = $clog2(NUM_PE);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(NUM_PE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {FILL, ISSUE, HOLD, DONE} state_t;

  state_t                                         state;
  logic [RW-1:0]                                  row_cnt;
  logic [HW-1:0]                                  hold_cnt;
  logic [0:NUM_PE-1][0:NUM_PE-1][CHUNK_WIDTH-1:0] buffer;
  logic                                           in_ready_q;
  logic                                           xpose_q;
  logic                                           busy_q;
  logic                                           done_q;

  // Outputs are registered alongside the state so each reflects the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      row_cnt    <= '0;
      hold_cnt   <= '0;
      buffer     <= '0;
      in_ready_q <= 1'b1;
      xpose_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.flush) begin
      // Abort keeps the buffer contents; a row offered in the same cycle is dropped.
      state      <= FILL;
      row_cnt    <= '0;
      hold_cnt   <= '0;
      in_ready_q <= 1'b1;
      xpose_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid && in_ready_q) begin
            buffer[row_cnt] <= bus.in_row;
            if (row_cnt == ROW_LAST) begin
              row_cnt    <= '0;
              state      <= ISSUE;
              in_ready_q <= 1'b0;
              xpose_q    <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          hold_cnt <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state   <= DONE;
            xpose_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state      <= FILL;
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state      <= FILL;
          in_ready_q <= 1'b1;
          xpose_q    <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.xpose_ctrl   = xpose_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mat_elements = buffer;
endmodule
